// File: rtl/decoder_bool.sv
// decoder_bool: registered 3-to-8 one-hot decoder built from explicit minterm equations
module decoder_bool #(
  parameter logic ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  input  logic C,
  output logic d0,
  output logic d1,
  output logic d2,
  output logic d3,
  output logic d4,
  output logic d5,
  output logic d6,
  output logic d7
);
  logic na, nb, nc;
  logic [7:0] dec, q;
  assign na = ~A;
  assign nb = ~B;
  assign nc = ~C;
  assign dec[0] = nc & nb & na;
  assign dec[1] = nc & nb & A;
  assign dec[2] = nc & B & na;
  assign dec[3] = nc & B & A;
  assign dec[4] = C & nb & na;
  assign dec[5] = C & nb & A;
  assign dec[6] = C & B & na;
  assign dec[7] = C & B & A;
  always_ff @(posedge clk)
    q <= rst ? {8{ACTIVE_LOW}} : dec ^ {8{ACTIVE_LOW}};
  assign {d7, d6, d5, d4, d3, d2, d1, d0} = q;
endmodule

// File: tb/tb_decoder_bool.sv
// tb_decoder_bool: scoreboard check of both polarities plus a running one-hot invariant
module tb_decoder_bool;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic A = 1'b0, B = 1'b0, C = 1'b0;
  logic [7:0] y0, y1;
  logic [7:0] q[$];
  logic [7:0] e;
  logic live = 1'b0, rsted = 1'b0;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  decoder_bool #(.ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C),
    .d0(y0[0]), .d1(y0[1]), .d2(y0[2]), .d3(y0[3]),
    .d4(y0[4]), .d5(y0[5]), .d6(y0[6]), .d7(y0[7])
  );
  decoder_bool #(.ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C),
    .d0(y1[0]), .d1(y1[1]), .d2(y1[2]), .d3(y1[3]),
    .d4(y1[4]), .d5(y1[5]), .d6(y1[6]), .d7(y1[7])
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] s);
    logic [7:0] one;
    one = 8'h01;
    @(negedge clk);
    rst = r;
    {C, B, A} = s;
    q.push_back(r ? 8'h00 : one << s);
  endtask

  task automatic capture(input string tag);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = q.pop_front();
      chk(tag, y0, e);
      chk({tag, "_al"}, y1, ~e);
    end
  endtask

  task automatic apply(input string tag, input logic r, input logic [2:0] s);
    drive(r, s);
    capture(tag);
  endtask

  always @(posedge clk) begin
    live <= !rst;
    rsted <= rst;
  end

  always @(negedge clk) begin
    if (live) begin
      chk("onehot", 8'($countones(y0)), 8'd1);
      chk("onehot_al", 8'($countones(~y1)), 8'd1);
    end else if (rsted) begin
      chk("idle", 8'($countones(y0)), 8'd0);
      chk("idle_al", 8'($countones(~y1)), 8'd0);
    end
  end

  initial begin
    apply("reset0", 1'b1, 3'b101);
    apply("reset1", 1'b1, 3'b101);
    for (int i = 0; i < 8; i++) apply($sformatf("sweep%0d", i), 1'b0, 3'(i));
    apply("lat_pre", 1'b0, 3'b000);
    #1 A = 1'b1;
    @(negedge clk);
    chk("lat_hold", y0, 8'h01);
    chk("lat_hold_al", y1, 8'hfe);
    q.push_back(8'h02);
    capture("lat_post");
    apply("mid_pre", 1'b0, 3'b110);
    apply("mid_rst", 1'b1, 3'b110);
    apply("mid_rel", 1'b0, 3'b110);
    for (int i = 0; i < 3; i++) apply("hold", 1'b0, 3'b011);
    for (int i = 0; i < 1000; i++)
      apply("rand", ($urandom_range(0, 19) == 0), 3'($urandom_range(0, 7)));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/decoder_bool.md
Name: decoder_bool

Overview:
- 3-to-8 binary decoder built from explicit Boolean minterm equations: inverters plus 3-input ANDs, one per output.
- Outputs are registered on a single clock, with a synchronous active-high reset.
- Serves as a one-hot select generator, e.g. for register-file write enables or chip selects, wherever a 3-bit code must drive exactly one of eight lines.

Parameters:
- ACTIVE_LOW, 0, output polarity. 0 means the selected output is 1 and the others are 0. 1 means all outputs are inverted: the selected output is 0 and the others are 1.

Ports:
- clk  input  1  rising-edge clock; the only clock in the block
- rst  input  1  synchronous, active-high reset
- A  input  1  select bit 0 (LSB)
- B  input  1  select bit 1
- C  input  1  select bit 2 (MSB)
- d0  output  1  active when {C,B,A} = 3'b000
- d1  output  1  active when {C,B,A} = 3'b001
- d2  output  1  active when {C,B,A} = 3'b010
- d3  output  1  active when {C,B,A} = 3'b011
- d4  output  1  active when {C,B,A} = 3'b100
- d5  output  1  active when {C,B,A} = 3'b101
- d6  output  1  active when {C,B,A} = 3'b110
- d7  output  1  active when {C,B,A} = 3'b111

Behaviour:
- Select index n = 4*C + 2*B + A. A is the LSB and C is the MSB; this bit order is fixed.
- Decode logic is written as explicit sum-of-minterm Boolean equations, e.g. d0_next = ~C & ~B & ~A and d5_next = C & ~B & A. No case statements and no shift operators.
- Every output dN is a flip-flop clocked on the rising edge of clk.
- Reset:
  - Reset is synchronous and active-high.
  - While rst = 1 at a rising edge, every dN loads the inactive level: 0 when ACTIVE_LOW = 0, 1 when ACTIVE_LOW = 1.
  - While reset is held, no output is ever active.
- Normal operation:
  - At each rising edge with rst = 0, output dn takes the active level and every other output takes the inactive level, where n is the index formed from the A/B/C values sampled at that edge.
- Latency:
  - Exactly one clock cycle from sampled input to output.
  - Input changes between edges have no effect on the outputs.
- One-hot invariant: after the first non-reset edge, exactly one output is active on every cycle. Zero active outputs or more than one active output is a design error.
- Reset asserted mid-operation: the outputs go inactive at the next rising edge, regardless of A/B/C.
- Reset released: the first edge with rst = 0 loads the decode of the A/B/C values present at that edge. There is no extra idle cycle.
- Same select held for several cycles: the outputs stay constant with no glitch between edges.
- Inputs are assumed synchronous to clk. X or Z on A/B/C is not defined behaviour; the block needs no special handling for it.
- No combinational path from inputs to outputs. No latches. No other state.

Test Plan:
- Reset: hold rst = 1 for 2 edges with {C,B,A} = 3'b101 -> all d0..d7 = 0. With ACTIVE_LOW = 1, all outputs = 1.
- Exhaustive sweep: release reset, then apply {C,B,A} = 000, 001, 010, 011, 100, 101, 110, 111 on successive edges, e.g. A=1,B=0,C=0 -> d1. At each edge +1 cycle, exactly dn = 1, where n = 0..7 in order, and the other seven outputs = 0.
- Latency check: change A from 0 to 1 just after an edge with B = C = 0 -> d0 stays 1 until the next edge, then d1 = 1 and d0 = 0.
- Reset mid-operation: with d6 active ({C,B,A} = 110), assert rst for 1 edge -> all outputs 0 at that edge. Deassert rst -> d6 = 1 again at the following edge.
- Polarity: with ACTIVE_LOW = 1, run the exhaustive sweep -> the selected dn = 0 and the other seven = 1 at every step.
- Invariant: a continuous assertion that the number of active outputs is exactly 1 on every cycle after the first non-reset edge, checked across 1000 random A/B/C cycles with occasional rst pulses. The count of active outputs is 0 only on cycles following a reset edge.
